bram_pingpong_bank: RTL and testbench
=====================================

Name: bram_pingpong_bank

Overview:
- Parametrised, double-buffered register bank for the YOLOv2 datapath.
- A loader fills one bank word by word, in either streaming (auto-increment) or addressed mode.
- The compute side reads every word of the other bank in parallel on one flat bus.
- Banks swap automatically when the fill bank is complete and the read bank has been released, so loading of tile N+1 overlaps compute on tile N.

Parameters:
- RAM_WIDTH, 16, data width of one entry in bits.
- RAM_DEPTH, 11, entries per bank (must be ≥2).
- AW, clogb2(RAM_DEPTH-1), address and counter width; derived, not overridable.

Ports:
- clka  in  1  clock; all logic on rising edge.
- rst_na  in  1  synchronous active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  fill bank can accept a write.
- wr_data  in  RAM_WIDTH  write data.
- wr_addr_en  in  1  1: use wr_addr; 0: use internal stream pointer.
- wr_addr  in  AW  explicit entry index.
- wr_err  out  1  one-cycle pulse: addressed write dropped (wr_addr ≥ RAM_DEPTH).
- fill_count  out  AW+1  number of distinct valid entries in fill bank.
- rd_valid  out  1  read bank holds a complete tile.
- rd_release  in  1  consumer is done with the read bank.
- douta  out  RAM_WIDTH*RAM_DEPTH  read bank contents; entry i at [i*RAM_WIDTH +: RAM_WIDTH].

Behaviour:

Reset (rst_na=0 at an edge):
- Both banks cleared to 0.
- fill_sel=0, valid bitmap=0, stream pointer=0, rd_valid=0, wr_err=0.
- After reset: douta=0, fill_count=0, wr_ready=1.
- Reset mid-fill or mid-read discards everything; there is no partial-state retention.

State:
- fill_sel (bank being written; the read bank is ~fill_sel).
- RAM_DEPTH-bit valid bitmap for the fill bank.
- Stream pointer (0..RAM_DEPTH-1).
- rd_valid.

Write path:
- fill_full = all valid bits set.
- wr_ready = !fill_full (combinational from registers).
- A write is accepted when wr_valid && wr_ready at the edge.
- Target index: wr_addr if wr_addr_en=1, else the stream pointer.
- Stream pointer increments only on accepted stream writes, wrapping RAM_DEPTH-1 → 0. Addressed writes do not move it.
- Accepted write stores wr_data at the target and sets its valid bit.
- Rewriting an already-valid entry overwrites the data; fill_count is unchanged.
- Addressed write with wr_addr ≥ RAM_DEPTH: no store, no bit set, wr_err=1 for the next cycle only. wr_err=0 otherwise.
- fill_count = popcount(valid bitmap), registered value.

Swap/read path:
- swap = fill_full && (!rd_valid || rd_release), evaluated at each edge. On swap:
  - fill_sel toggles.
  - Valid bitmap and stream pointer cleared.
  - rd_valid=1.
- Swap latency: the write completing a bank is accepted at edge k. If the read bank is free, swap occurs at edge k+1, so rd_valid is high after k+1. wr_ready is low for at least the cycle between k and k+1.
- rd_release && rd_valid with no swap → rd_valid=0 next edge.
- rd_release while rd_valid=0 is ignored.
- rd_release in the same cycle as fill_full → swap happens and rd_valid stays 1 (new tile, no bubble).
- douta always shows bank[~fill_sel], including when rd_valid=0 (stale data, held).
- douta changes only at a swap or at reset; it never changes during fills.
- Newly filled bank contents are not cleared on swap. Entries are fully rewritten before the next full flag, since the bitmap requires all entries.

Test Plan:
- Reset, then stream 11 writes 0x0001..0x000B with wr_addr_en=0 → fill_count reaches 11; wr_ready=0 for 1 cycle; rd_valid=1; douta[15:0]=0x0001, douta[175:160]=0x000B; wr_ready=1, fill_count=0.
- Hold rd_release=0 and stream 11 more words 0x0100..0x010A → wr_ready stays 0 after the 11th and douta is unchanged. Pulse rd_release → swap next edge; douta[15:0]=0x0100; rd_valid remains 1.
- Addressed writes to indices 10,9,…,0 with data 0xA000+idx, plus a rewrite of idx 3 with 0xBEEF before completion → fill_count stops at 11 only after idx 0; douta[63:48]=0xBEEF.
- Addressed write with wr_addr=12 → wr_err pulses 1 cycle; fill_count unchanged; no douta change after the bank later swaps in except the legal entries.
- rd_release asserted on the same edge the fill bank becomes full-evaluable → rd_valid never drops; douta switches to the new tile.
- Assert rst_na=0 after 5 stream writes while rd_valid=1 → next cycle rd_valid=0, douta=0, fill_count=0, wr_ready=1; the stream restarts at index 0.

Source files
------------

// File: rtl/bram_pingpong_bank.sv
// Double-buffered register bank with ping-pong swap.
// A loader fills one bank in stream or addressed mode while the compute side
// reads all entries of the other bank on one flat bus. The banks swap when the
// fill bank is complete and the read bank is free or being released.
//
// Ports:
//   clka        clock, rising edge
//   rst_na      synchronous active-low reset
//   wr_valid    write request
//   wr_ready    fill bank can accept a write (not full)
//   wr_data     write data
//   wr_addr_en  1: use wr_addr, 0: use internal stream pointer
//   wr_addr     explicit entry index
//   wr_err      one-cycle pulse after an out-of-range addressed write
//   fill_count  number of distinct valid entries in the fill bank
//   rd_valid    read bank holds a complete tile
//   rd_release  consumer is done with the read bank
//   douta       read bank contents, entry i at [i*RAM_WIDTH +: RAM_WIDTH]
module bram_pingpong_bank #(
  parameter int unsigned RAM_WIDTH = 16,
  parameter int unsigned RAM_DEPTH = 11,
  localparam int unsigned AW = $clog2(RAM_DEPTH)
) (
  input  logic                           clka,
  input  logic                           rst_na,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [RAM_WIDTH-1:0]           wr_data,
  input  logic                           wr_addr_en,
  input  logic [AW-1:0]                  wr_addr,
  output logic                           wr_err,
  output logic [AW:0]                    fill_count,
  output logic                           rd_valid,
  input  logic                           rd_release,
  output logic [RAM_WIDTH*RAM_DEPTH-1:0] douta
);

  logic [RAM_WIDTH-1:0] bank_q [2][RAM_DEPTH];
  logic [RAM_WIDTH-1:0] bank_d [2][RAM_DEPTH];
  logic                 fill_sel_q, fill_sel_d;
  logic [RAM_DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_err_q, wr_err_d;
  logic [AW:0]          fill_count_q, fill_count_d;

  logic          fill_full;
  logic          wr_fire;
  logic          addr_bad;
  logic          swap;
  logic [AW-1:0] tgt;
  logic          rd_sel;

  // Handshake and swap decisions, all from registered state
  assign fill_full = &valid_q;
  assign wr_ready  = ~fill_full;
  assign wr_fire   = wr_valid & ~fill_full;
  assign addr_bad  = wr_addr_en & ({1'b0, wr_addr} >= (AW+1)'(RAM_DEPTH));
  assign tgt       = wr_addr_en ? wr_addr : ptr_q;
  assign swap      = fill_full & (~rd_valid_q | rd_release);
  assign rd_sel    = ~fill_sel_q;

  // Next-state: write into fill bank, then swap/release handling
  always_comb begin
    bank_d       = bank_q;
    valid_d      = valid_q;
    ptr_d        = ptr_q;
    fill_sel_d   = fill_sel_q;
    rd_valid_d   = rd_valid_q;
    wr_err_d     = 1'b0;
    fill_count_d = '0;

    if (wr_fire) begin
      if (addr_bad) begin
        wr_err_d = 1'b1;
      end else begin
        bank_d[fill_sel_q][tgt] = wr_data;
        valid_d[tgt]            = 1'b1;
      end
      // Only stream writes advance the pointer
      if (!wr_addr_en) begin
        ptr_d = (ptr_q == AW'(RAM_DEPTH - 1)) ? '0 : ptr_q + AW'(1);
      end
    end

    // A swap never coincides with an accepted write: fill_full blocks writes
    if (swap) begin
      fill_sel_d = ~fill_sel_q;
      valid_d    = '0;
      ptr_d      = '0;
      rd_valid_d = 1'b1;
    end else if (rd_release && rd_valid_q) begin
      rd_valid_d = 1'b0;
    end

    // Registered popcount tracks the bitmap being written this edge
    for (int unsigned i = 0; i < RAM_DEPTH; i++) begin
      fill_count_d = fill_count_d + (AW+1)'(valid_d[i]);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clka) begin
    if (!rst_na) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned i = 0; i < RAM_DEPTH; i++) begin
          bank_q[b][i] <= '0;
        end
      end
      fill_sel_q   <= 1'b0;
      valid_q      <= '0;
      ptr_q        <= '0;
      rd_valid_q   <= 1'b0;
      wr_err_q     <= 1'b0;
      fill_count_q <= '0;
    end else begin
      bank_q       <= bank_d;
      fill_sel_q   <= fill_sel_d;
      valid_q      <= valid_d;
      ptr_q        <= ptr_d;
      rd_valid_q   <= rd_valid_d;
      wr_err_q     <= wr_err_d;
      fill_count_q <= fill_count_d;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign wr_err     = wr_err_q;
  assign fill_count = fill_count_q;

  // Flat read bus from the non-fill bank
  for (genvar g = 0; g < int'(RAM_DEPTH); g++) begin : g_douta
    assign douta[g*RAM_WIDTH +: RAM_WIDTH] = bank_q[rd_sel][g];
  end

endmodule

// File: tb/tb_bram_pingpong_bank.sv
module tb_bram_pingpong_bank;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 11;
  localparam int unsigned AW = 4;

  logic           clka = 1'b0;
  logic           rst_na;
  logic           wr_valid;
  logic           wr_ready;
  logic [W-1:0]   wr_data;
  logic           wr_addr_en;
  logic [AW-1:0]  wr_addr;
  logic           wr_err;
  logic [AW:0]    fill_count;
  logic           rd_valid;
  logic           rd_release;
  logic [W*D-1:0] douta;

  int total = 0;
  int bad   = 0;

  bram_pingpong_bank #(.RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
    .clka       (clka),
    .rst_na     (rst_na),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_addr_en (wr_addr_en),
    .wr_addr    (wr_addr),
    .wr_err     (wr_err),
    .fill_count (fill_count),
    .rd_valid   (rd_valid),
    .rd_release (rd_release),
    .douta      (douta)
  );

  always #5 clka = ~clka;

  typedef struct {
    logic        rst_n;
    logic        wv;
    logic        ae;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        rel;
    logic        rdy;
    logic        err;
    logic [4:0]  cnt;
    logic        rv;
    logic [15:0] d0;
    logic [15:0] d3;
    logic [15:0] d10;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst_n, input logic wv, input logic ae,
                     input logic [3:0] addr, input logic [15:0] data, input logic rel,
                     input logic rdy, input logic err, input logic [4:0] cnt,
                     input logic rv, input logic [15:0] d0, input logic [15:0] d3,
                     input logic [15:0] d10);
    vec_t v;
    v.rst_n = rst_n; v.wv = wv; v.ae = ae; v.addr = addr; v.data = data; v.rel = rel;
    v.rdy = rdy; v.err = err; v.cnt = cnt; v.rv = rv; v.d0 = d0; v.d3 = d3; v.d10 = d10;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h exp=%h", name, row, got, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic wv, input logic ae,
                       input logic [3:0] addr, input logic [15:0] data, input logic rel);
    rst_na = rst_n; wr_valid = wv; wr_addr_en = ae; wr_addr = addr;
    wr_data = data; rd_release = rel;
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  function automatic logic [15:0] entry(input int i);
    return douta[i*W +: W];
  endfunction

  // Bounded wait for a swap; an expired budget is reported as a failure
  task automatic wait_rv(input string name);
    for (int n = 0; n < 4; n++) begin
      if (rd_valid) break;
      tick();
    end
    chk(name, -1, {31'b0, rd_valid}, 32'd1);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    tick();
    tick();

    // Reset state
    add(0,0,0,0,16'h0,0, 1,0,5'd0,0, 16'h0,16'h0,16'h0);
    // Stream tile 1..11 into an idle bank
    for (int i = 1; i <= 11; i++)
      add(1,1,0,0,16'(i),0, (i < 11),0,5'(i),0, 16'h0,16'h0,16'h0);
    // Swap one edge after the completing write
    add(1,0,0,0,16'h0,0, 1,0,5'd0,1, 16'h0001,16'h0004,16'h000B);
    // Stream second tile while read bank is held
    for (int i = 0; i < 11; i++)
      add(1,1,0,0,16'h0100 + 16'(i),0, (i < 10),0,5'(i + 1),1, 16'h0001,16'h0004,16'h000B);
    // Full and not released: write refused, nothing moves
    add(1,1,0,0,16'hDEAD,0, 0,0,5'd11,1, 16'h0001,16'h0004,16'h000B);
    // Release: swap, rd_valid stays high
    add(1,0,0,0,16'h0,1, 1,0,5'd0,1, 16'h0100,16'h0103,16'h010A);
    // Addressed writes 10 down to 3
    for (int k = 0; k < 8; k++)
      add(1,1,1,4'(10 - k),16'hA000 + 16'(10 - k),0, 1,0,5'(k + 1),1,
          16'h0100,16'h0103,16'h010A);
    // Rewrite of a valid entry keeps the count
    add(1,1,1,4'd3,16'hBEEF,0, 1,0,5'd8,1, 16'h0100,16'h0103,16'h010A);
    // Out-of-range address: error pulse, no store
    add(1,1,1,4'd12,16'h5555,0, 1,1,5'd8,1, 16'h0100,16'h0103,16'h010A);
    add(1,1,1,4'd2,16'hA002,0, 1,0,5'd9,1, 16'h0100,16'h0103,16'h010A);
    add(1,1,1,4'd1,16'hA001,0, 1,0,5'd10,1, 16'h0100,16'h0103,16'h010A);
    add(1,1,1,4'd0,16'hA000,0, 0,0,5'd11,1, 16'h0100,16'h0103,16'h010A);
    // Release while full: swap with no bubble
    add(1,0,0,0,16'h0,1, 1,0,5'd0,1, 16'hA000,16'hBEEF,16'hA00A);
    // Release with nothing to swap in: rd_valid drops, data held
    add(1,0,0,0,16'h0,1, 1,0,5'd0,0, 16'hA000,16'hBEEF,16'hA00A);
    // Release while not valid: ignored
    add(1,0,0,0,16'h0,1, 1,0,5'd0,0, 16'hA000,16'hBEEF,16'hA00A);

    foreach (tbl[r]) begin
      drive(tbl[r].rst_n, tbl[r].wv, tbl[r].ae, tbl[r].addr, tbl[r].data, tbl[r].rel);
      tick();
      chk("wr_ready",   r, {31'b0, wr_ready},   {31'b0, tbl[r].rdy});
      chk("wr_err",     r, {31'b0, wr_err},     {31'b0, tbl[r].err});
      chk("fill_count", r, {27'b0, fill_count}, {27'b0, tbl[r].cnt});
      chk("rd_valid",   r, {31'b0, rd_valid},   {31'b0, tbl[r].rv});
      chk("douta_e0",   r, {16'b0, entry(0)},   {16'b0, tbl[r].d0});
      chk("douta_e3",   r, {16'b0, entry(3)},   {16'b0, tbl[r].d3});
      chk("douta_e10",  r, {16'b0, entry(10)},  {16'b0, tbl[r].d10});
    end

    // Addressed tile: every legal entry, nothing from the dropped write
    for (int i = 0; i < 11; i++)
      chk("addr_tile", i, {16'b0, entry(i)},
          {16'b0, (i == 3) ? 16'hBEEF : 16'hA000 + 16'(i)});

    // Fill a tile into a free read slot
    for (int i = 0; i < 11; i++) begin
      drive(1, 1, 0, 4'd0, 16'h0200 + 16'(i), 0);
      tick();
    end
    drive(1, 0, 0, 4'd0, 16'h0, 0);
    wait_rv("swap_wait_a");
    chk("tile2_e0", 0, {16'b0, entry(0)}, 32'h0200);

    // Partial fill, then reset while the read bank is valid
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 4'd0, 16'h0300 + 16'(i), 0);
      tick();
    end
    chk("partial_cnt", 0, {27'b0, fill_count}, 32'd5);
    drive(0, 0, 0, 4'd0, 16'h0, 0);
    tick();
    chk("rst_rd_valid", 0, {31'b0, rd_valid}, 32'd0);
    chk("rst_douta",    0, {31'b0, |douta},   32'd0);
    chk("rst_cnt",      0, {27'b0, fill_count}, 32'd0);
    chk("rst_ready",    0, {31'b0, wr_ready}, 32'd1);
    chk("rst_err",      0, {31'b0, wr_err},   32'd0);

    // Stream restarts at index 0 after reset
    for (int i = 0; i < 11; i++) begin
      drive(1, 1, 0, 4'd0, 16'h0400 + 16'(i), 0);
      tick();
    end
    drive(1, 0, 0, 4'd0, 16'h0, 0);
    wait_rv("swap_wait_b");
    for (int i = 0; i < 11; i++)
      chk("restart_tile", i, {16'b0, entry(i)}, {16'b0, 16'h0400 + 16'(i)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
